// File: rtl/sram_arbiter_rr_pkg.sv
// Shared constants, init-clear state encodings and pointer helper
// for the round-robin ZBT SRAM arbiter.
package sram_arbiter_rr_pkg;

   localparam logic SRAM_ARB_BW_ON  = 1'b0;
   localparam logic SRAM_ARB_BW_OFF = 1'b1;

   localparam int RD_LATENCY_MIN = 2;
   localparam int RD_LATENCY_MAX = 6;

   typedef enum logic [1:0] {
      INIT_IDLE  = 2'd0,
      INIT_CLEAR = 2'd1,
      INIT_DONE  = 2'd2
   } init_state_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester at or after rr_ptr,
// modulo NUM_PORTS; one-hot grant plus its index.
module sram_arbiter_rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 gnt_vld
);

   // scan ports starting at the pointer and take the first request
   always_comb begin
      int p;
      p       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         p = int'(rr_ptr) + k;
         if (p >= NUM_PORTS) p = p - NUM_PORTS;
         if (!gnt_vld && req[p]) begin
            gnt_vld = 1'b1;
            gnt[p]  = 1'b1;
            gnt_idx = IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/sram_arbiter_rr.sv
// N-port round-robin arbiter for a ZBT SRAM with pipelined read return.
// Optional post-reset memory clear: define SRAM_ARB_INIT_EN.
module sram_arbiter_rr
   import sram_arbiter_rr_pkg::*;
#(
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int SRAM_DATA_WIDTH = 36,
   parameter int NUM_PORTS       = 4,
   parameter int RD_LATENCY      = 3,
   parameter logic [SRAM_DATA_WIDTH-1:0] INIT_PATTERN = '0
) (
   input  logic                                 clk,
   input  logic                                 reset_L,
   input  logic [NUM_PORTS-1:0]                 req,
   input  logic [NUM_PORTS-1:0]                 rd_wr_L,
   input  logic [NUM_PORTS*SRAM_ADDR_WIDTH-1:0] addr,
   input  logic [NUM_PORTS*SRAM_DATA_WIDTH-1:0] wr_data,
   output logic [NUM_PORTS-1:0]                 ack,
   output logic [NUM_PORTS-1:0]                 rd_vld,
   output logic [SRAM_DATA_WIDTH-1:0]           rd_data,
   output logic [SRAM_ADDR_WIDTH-1:0]           sram_addr,
   output logic                                 sram_we,
   output logic [SRAM_DATA_WIDTH/9-1:0]         sram_bw,
   output logic [SRAM_DATA_WIDTH-1:0]           sram_wr_data,
   input  logic [SRAM_DATA_WIDTH-1:0]           sram_rd_data,
   output logic                                 sram_tri_en,
   output logic                                 enable
);

   localparam int AW    = SRAM_ADDR_WIDTH;
   localparam int DW    = SRAM_DATA_WIDTH;
   localparam int BW    = SRAM_DATA_WIDTH / 9;
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int RDL   =
      (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
      (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

   logic [NUM_PORTS-1:0] gnt;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_vld;

   logic [NUM_PORTS-1:0] ack_q, ack_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]        sram_addr_q, sram_addr_d;
   logic                 sram_we_q, sram_we_d;
   logic [BW-1:0]        sram_bw_q, sram_bw_d;
   logic                 wr0_q, wr0_d, wr1_q, wr1_d;
   logic [DW-1:0]        wd0_q, wd0_d, wd1_q, wd1_d;
   logic                 tri_en_q, tri_en_d;
   logic [DW-1:0]        sram_wr_data_q, sram_wr_data_d;
   logic [NUM_PORTS-1:0] rd_pipe_q [RDL];
   logic [NUM_PORTS-1:0] rd_pipe_d [RDL];
   logic [NUM_PORTS-1:0] rd_vld_q, rd_vld_d;
   logic [DW-1:0]        rd_data_q, rd_data_d;
   logic                 enable_q, enable_d;

   logic                 clr_wr;
   logic [AW-1:0]        clr_addr;

   sram_arbiter_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

`ifdef SRAM_ARB_INIT_EN
   init_state_e   state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;

   assign clr_addr = clr_addr_q;

   // clear walk: one INIT_PATTERN write per cycle, then open service
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_wr     = 1'b0;
      enable_d   = enable_q;
      unique case (state_q)
         INIT_IDLE: state_d = INIT_CLEAR;
         INIT_CLEAR: begin
            clr_wr     = 1'b1;
            clr_addr_d = clr_addr_q + AW'(1);
            if (&clr_addr_q) state_d = INIT_DONE;
         end
         INIT_DONE: enable_d = 1'b1;
         default: state_d = INIT_IDLE;
      endcase
   end

   // clear FSM state register
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= INIT_IDLE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end
`else
   assign clr_wr   = 1'b0;
   assign clr_addr = '0;
   assign enable_d = 1'b1;
`endif

   // grant, SRAM control pins, write-data delay and read-valid pipe
   always_comb begin
      int sel;
      sel            = int'(gnt_idx);
      ack_d          = '0;
      rr_ptr_d       = rr_ptr_q;
      sram_addr_d    = sram_addr_q;
      sram_we_d      = 1'b1;
      sram_bw_d      = {BW{SRAM_ARB_BW_OFF}};
      wr0_d          = 1'b0;
      wd0_d          = wd0_q;
      wr1_d          = wr0_q;
      wd1_d          = wd0_q;
      tri_en_d       = wr1_q;
      sram_wr_data_d = wd1_q;
      rd_pipe_d[0]   = '0;
      for (int k = 1; k < RDL; k++) rd_pipe_d[k] = rd_pipe_q[k-1];
      rd_vld_d       = rd_pipe_q[RDL-1];
      rd_data_d      = (|rd_pipe_q[RDL-1]) ? sram_rd_data : rd_data_q;
      if (clr_wr) begin
         sram_addr_d = clr_addr;
         sram_we_d   = 1'b0;
         sram_bw_d   = {BW{SRAM_ARB_BW_ON}};
         wr0_d       = 1'b1;
         wd0_d       = INIT_PATTERN;
      end else if (enable_q && gnt_vld) begin
         ack_d       = gnt;
         rr_ptr_d    = IDX_W'(rr_next(sel, NUM_PORTS));
         sram_addr_d = addr[sel*AW +: AW];
         if (rd_wr_L[sel]) begin
            rd_pipe_d[0] = gnt;
         end else begin
            sram_we_d = 1'b0;
            sram_bw_d = {BW{SRAM_ARB_BW_ON}};
            wr0_d     = 1'b1;
            wd0_d     = wr_data[sel*DW +: DW];
         end
      end
   end

   // datapath registers; reset drops any in-flight read
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ack_q          <= '0;
         rr_ptr_q       <= '0;
         sram_addr_q    <= '0;
         sram_we_q      <= 1'b1;
         sram_bw_q      <= {BW{SRAM_ARB_BW_OFF}};
         wr0_q          <= 1'b0;
         wr1_q          <= 1'b0;
         wd0_q          <= '0;
         wd1_q          <= '0;
         tri_en_q       <= 1'b0;
         sram_wr_data_q <= '0;
         for (int k = 0; k < RDL; k++) rd_pipe_q[k] <= '0;
         rd_vld_q       <= '0;
         rd_data_q      <= '0;
         enable_q       <= 1'b0;
      end else begin
         ack_q          <= ack_d;
         rr_ptr_q       <= rr_ptr_d;
         sram_addr_q    <= sram_addr_d;
         sram_we_q      <= sram_we_d;
         sram_bw_q      <= sram_bw_d;
         wr0_q          <= wr0_d;
         wr1_q          <= wr1_d;
         wd0_q          <= wd0_d;
         wd1_q          <= wd1_d;
         tri_en_q       <= tri_en_d;
         sram_wr_data_q <= sram_wr_data_d;
         for (int k = 0; k < RDL; k++) rd_pipe_q[k] <= rd_pipe_d[k];
         rd_vld_q       <= rd_vld_d;
         rd_data_q      <= rd_data_d;
         enable_q       <= enable_d;
      end
   end

   assign ack          = ack_q;
   assign rd_vld       = rd_vld_q;
   assign rd_data      = rd_data_q;
   assign sram_addr    = sram_addr_q;
   assign sram_we      = sram_we_q;
   assign sram_bw      = sram_bw_q;
   assign sram_wr_data = sram_wr_data_q;
   assign sram_tri_en  = tri_en_q;
   assign enable       = enable_q;

endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Directed bench for sram_arbiter_rr with a small ZBT SRAM model.
// Default build checks immediate enable; SRAM_ARB_INIT_EN checks the clear.
module tb_sram_arbiter_rr;

   localparam int N   = 4;
   localparam int DW  = 36;
   localparam int RDL = 3;
`ifdef SRAM_ARB_INIT_EN
   localparam int AW  = 4;
`else
   localparam int AW  = 19;
`endif

   logic            clk;
   logic            reset_L;
   logic [N-1:0]    req;
   logic [N-1:0]    rd_wr_L;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wr_data;
   logic [N-1:0]    ack;
   logic [N-1:0]    rd_vld;
   logic [DW-1:0]   rd_data;
   logic [AW-1:0]   sram_addr;
   logic            sram_we;
   logic [DW/9-1:0] sram_bw;
   logic [DW-1:0]   sram_wr_data;
   logic [DW-1:0]   sram_rd_data;
   logic            sram_tri_en;
   logic            enable;

   int errors = 0;
   int checks = 0;

   sram_arbiter_rr #(
      .SRAM_ADDR_WIDTH (AW),
      .SRAM_DATA_WIDTH (DW),
      .NUM_PORTS       (N),
      .RD_LATENCY      (RDL),
      .INIT_PATTERN    ('0)
   ) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .req          (req),
      .rd_wr_L      (rd_wr_L),
      .addr         (addr),
      .wr_data      (wr_data),
      .ack          (ack),
      .rd_vld       (rd_vld),
      .rd_data      (rd_data),
      .sram_addr    (sram_addr),
      .sram_we      (sram_we),
      .sram_bw      (sram_bw),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data),
      .sram_tri_en  (sram_tri_en),
      .enable       (enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] dflt(input logic [7:0] a);
      return {28'h0C00000, a};
   endfunction

   function automatic logic [7:0] lo(input int a);
      logic [AW-1:0] t;
      t = AW'(a);
      return 8'(t);
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int a);
`ifdef SRAM_ARB_INIT_EN
      return (lo(a) < 8'd16) ? '0 : dflt(lo(a));
`else
      return dflt(lo(a));
`endif
   endfunction

   // ZBT model: ctrl sampled one edge after the pins, data two edges later
   logic [DW-1:0] mem [256];
   logic [255:0]  mem_ok;
   logic          s1_wr, s2_wr;
   logic [7:0]    s1_a, s2_a;

   // SRAM model pipeline
   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         s1_wr        <= 1'b0;
         s2_wr        <= 1'b0;
         s1_a         <= '0;
         s2_a         <= '0;
         mem_ok       <= '0;
         sram_rd_data <= '0;
      end else begin
         s1_wr <= !sram_we;
         s1_a  <= 8'(sram_addr);
         s2_wr <= s1_wr;
         s2_a  <= s1_a;
         if (s2_wr && sram_tri_en) begin
            mem[s2_a]    <= sram_wr_data;
            mem_ok[s2_a] <= 1'b1;
         end
         sram_rd_data <= mem_ok[s1_a] ? mem[s1_a] : dflt(s1_a);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic rd, input int a,
                        input logic [DW-1:0] d);
      req[p]             = 1'b1;
      rd_wr_L[p]         = rd;
      addr[p*AW +: AW]   = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_vld"}, rd_vld, 0);
      chk({tag, "_tri"}, sram_tri_en, 0);
      chk({tag, "_en"}, enable, 0);
      chk({tag, "_addr"}, sram_addr, 0);
      chk({tag, "_rdd"}, rd_data, 0);
      chk({tag, "_we"}, sram_we, 1);
      chk({tag, "_bw"}, sram_bw, 4'hF);
   endtask

   initial begin
      logic [N-1:0]  oh;
      logic [AW-1:0] ea;
      reset_L = 1'b0;
      req     = '0;
      rd_wr_L = '1;
      addr    = '0;
      wr_data = '0;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      reset_L = 1'b1;

`ifdef SRAM_ARB_INIT_EN
      drive(3, 1'b1, 0, '0);
      @(negedge clk);
      chk("idle_we", sram_we, 1);
      chk("idle_en", enable, 0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("clr_we", sram_we, 0);
         chk("clr_addr", sram_addr, 64'(k));
         chk("clr_ack", ack, 0);
         chk("clr_en", enable, 0);
      end
      @(negedge clk);
      chk("done_en", enable, 1);
      chk("done_ack", ack, 0);
      @(negedge clk);
      chk("first_ack", ack, 4'b1000);
      req = '0;
      repeat (5) @(negedge clk);
`else
      @(negedge clk);
      chk("en_first", enable, 1);
      chk("en_ack", ack, 0);
      drive(3, 1'b0, 'h0AA, 36'h123456789);
      @(negedge clk);
      chk("w6_ack", ack, 4'b1000);
      chk("w6_we", sram_we, 0);
      chk("w6_bw", sram_bw, 0);
      chk("w6_addr", sram_addr, 64'h0AA);
      req = '0;
      @(negedge clk);
      chk("w6_tri_t1", sram_tri_en, 0);
      chk("idle_we", sram_we, 1);
      chk("idle_bw", sram_bw, 4'hF);
      @(negedge clk);
      chk("w6_tri_t2", sram_tri_en, 1);
      chk("w6_wdata", sram_wr_data, 36'h123456789);
      @(negedge clk);
      chk("idle_tri", sram_tri_en, 0);
      repeat (2) @(negedge clk);
`endif

      // all four ports hold reads for 8 cycles
      for (int i = 0; i < N; i++) drive(i, 1'b1, 'h100 + i, '0);
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         oh = N'(1) << (k % N);
         chk("rr_ack", ack, (k < 8) ? 64'(oh) : 64'd0);
         if (k >= 3) begin
            oh = N'(1) << ((k - 3) % N);
            chk("rr_vld", rd_vld, oh);
            chk("rr_data", rd_data, exp_rd('h100 + (k - 3) % N));
         end else begin
            chk("rr_vld0", rd_vld, 0);
         end
         if (k == 7) req = '0;
      end
      repeat (2) @(negedge clk);

      // write then read back through the SRAM model
      drive(2, 1'b0, 'h1234, 36'h5A5A5A5A5);
      @(negedge clk);
      ea = AW'(32'h1234);
      chk("w2_ack", ack, 4'b0100);
      chk("w2_we", sram_we, 0);
      chk("w2_bw", sram_bw, 0);
      chk("w2_addr", sram_addr, ea);
      req = '0;
      @(negedge clk);
      chk("w2_tri_t1", sram_tri_en, 0);
      @(negedge clk);
      chk("w2_tri_t2", sram_tri_en, 1);
      chk("w2_wdata", sram_wr_data, 36'h5A5A5A5A5);
      drive(1, 1'b1, 'h1234, '0);
      @(negedge clk);
      chk("r1_ack", ack, 4'b0010);
      chk("r1_we", sram_we, 1);
      chk("r1_bw", sram_bw, 4'hF);
      chk("r1_tri", sram_tri_en, 0);
      req = '0;
      @(negedge clk);
      chk("r1_vld_early", rd_vld, 0);
      @(negedge clk);
      chk("r1_vld_early2", rd_vld, 0);
      @(negedge clk);
      chk("r1_vld", rd_vld, 4'b0010);
      chk("r1_data", rd_data, 36'h5A5A5A5A5);
      @(negedge clk);
      chk("r1_vld_off", rd_vld, 0);
      chk("r1_data_hold", rd_data, 36'h5A5A5A5A5);

      // single held requester, then wrap to port 0
      drive(3, 1'b1, 'h300, '0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_ack", ack, 4'b1000);
      end
      req = '0;
      drive(0, 1'b1, 'h10, '0);
      drive(1, 1'b1, 'h11, '0);
      @(negedge clk);
      chk("wrap_ack", ack, 4'b0001);
      req = '0;
      repeat (5) @(negedge clk);

      // reset pulse with two reads in flight
      drive(1, 1'b1, 'h20, '0);
      drive(2, 1'b1, 'h21, '0);
      @(negedge clk);
      chk("f_ack1", ack, 4'b0010);
      @(negedge clk);
      chk("f_ack2", ack, 4'b0100);
      req = '0;
      reset_L = 1'b0;
      #1;
      chk_reset_state("mid");
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_vld", rd_vld, 0);
         if (k == 0) begin
`ifdef SRAM_ARB_INIT_EN
            chk("post_en", enable, 0);
`else
            chk("post_en", enable, 1);
`endif
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
